// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for pipe_stage_reg.
// master drives the beat in and takes it out; slave is the stage.
interface pipe_stage_reg_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register with flush and transfer counter.
// All outputs are decoded from flops; no input-to-output paths.
module pipe_stage_reg #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] xfer_count
);
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BUSY  = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             rdy_q;
  logic [DW-1:0]    main_q;
  logic [DW-1:0]    skid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             main_in;
  logic             main_skid;
  logic             skid_in;
  logic             valid;
  logic             xfer;

  always_comb begin
    valid     = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      BUSY: begin
        valid     = 1'b1;
        occupancy = 2'd1;
      end
      FULL: begin
        valid     = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  assign xfer = valid & bus.out_ready;

  always_comb begin
    state_d   = EMPTY;
    main_in   = 1'b0;
    main_skid = 1'b0;
    skid_in   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (bus.in_valid) begin
          state_d = BUSY;
          main_in = 1'b1;
        end
      end
      BUSY: begin
        state_d = BUSY;
        if (bus.in_valid && bus.out_ready) begin
          main_in = 1'b1;
        end else if (bus.in_valid) begin
          state_d = FULL;
          skid_in = 1'b1;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        state_d = FULL;
        if (bus.out_ready) begin
          state_d   = BUSY;
          main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      // held beats are dropped but the data flops keep their contents
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
      if (main_in)   main_q <= bus.in_data;
      if (main_skid) main_q <= skid_q;
      if (skid_in)   skid_q <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = valid;
  assign bus.out_data  = main_q;
  assign xfer_count    = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks for pipe_stage_reg.
// dut_a uses default widths, dut_b a 4-bit counter on the same stimulus.
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        rst;
  logic        fl;
  logic        iv;
  logic [31:0] id;
  logic        ordy;
  logic [1:0]  occ_a;
  logic [1:0]  occ_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DW(32)) ifa ();
  pipe_stage_reg_if #(.DW(32)) ifb ();

  assign ifa.in_valid  = iv;
  assign ifa.in_data   = id;
  assign ifa.out_ready = ordy;
  assign ifb.in_valid  = iv;
  assign ifb.in_data   = id;
  assign ifb.out_ready = ordy;

  pipe_stage_reg #(.DW(32), .CNT_W(16)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .flush      (fl),
    .bus        (ifa),
    .occupancy  (occ_a),
    .xfer_count (cnt_a)
  );

  pipe_stage_reg #(.DW(32), .CNT_W(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .flush      (fl),
    .bus        (ifb),
    .occupancy  (occ_b),
    .xfer_count (cnt_b)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, ".ov"}, 64'(ifa.out_valid), 64'd0);
    check({tag, ".ir"}, 64'(ifa.in_ready), 64'd1);
    check({tag, ".occ"}, 64'(occ_a), 64'd0);
    check({tag, ".od"}, 64'(ifa.out_data), 64'd0);
    check({tag, ".cnt"}, 64'(cnt_a), 64'd0);
    check({tag, ".cntb"}, 64'(cnt_b), 64'd0);
    check({tag, ".occb"}, 64'(occ_b), 64'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int          xn;
    logic [31:0] held;
    logic        stall;
    logic        acc;
    logic        xf;
    logic [31:0] nxt;
    rst = 1'b1; fl = 1'b0; iv = 1'b0; id = '0; ordy = 1'b0;
    tick();
    chk_reset("rst0");
    rst = 1'b0;

    // single beat
    iv = 1'b1; id = 32'hA5A5A5A5; ordy = 1'b1;
    tick();
    iv = 1'b0;
    check("single.ov", 64'(ifa.out_valid), 64'd1);
    check("single.od", 64'(ifa.out_data), 64'hA5A5A5A5);
    check("single.occ", 64'(occ_a), 64'd1);
    tick();
    check("single.ov2", 64'(ifa.out_valid), 64'd0);
    check("single.cnt", 64'(cnt_a), 64'd1);

    // back-pressure
    ordy = 1'b0; iv = 1'b1; id = 32'h1;
    tick();
    id = 32'h2;
    tick();
    check("bp.occ", 64'(occ_a), 64'd2);
    check("bp.ir", 64'(ifa.in_ready), 64'd0);
    check("bp.od", 64'(ifa.out_data), 64'h1);
    id = 32'h3;
    tick();
    check("bp.hold", 64'(ifa.out_data), 64'h1);
    check("bp.occ2", 64'(occ_a), 64'd2);
    iv = 1'b0; ordy = 1'b1;
    tick();
    check("bp.d2", 64'(ifa.out_data), 64'h2);
    check("bp.ov2", 64'(ifa.out_valid), 64'd1);
    check("bp.occ3", 64'(occ_a), 64'd1);
    tick();
    check("bp.empty", 64'(ifa.out_valid), 64'd0);
    check("bp.cnt", 64'(cnt_a), 64'd3);

    // streaming
    do_reset();
    iv = 1'b1; ordy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      id = 32'(i + 100);
      tick();
      check("strm.od", 64'(ifa.out_data), 64'(i + 100));
      check("strm.occ", 64'(occ_a), 64'd1);
    end
    check("strm.cnt", 64'(cnt_a), 64'd99);
    check("strm.cntb", 64'(cnt_b), 64'd3);
    iv = 1'b0;
    tick();
    check("strm.cnt2", 64'(cnt_a), 64'd100);

    // flush in FULL
    ordy = 1'b0; iv = 1'b1; id = 32'h5;
    tick();
    id = 32'h6;
    tick();
    check("fl.occ", 64'(occ_a), 64'd2);
    fl = 1'b1; id = 32'h9;
    tick();
    fl = 1'b0; iv = 1'b0; ordy = 1'b1;
    check("fl.ov", 64'(ifa.out_valid), 64'd0);
    check("fl.occ0", 64'(occ_a), 64'd0);
    check("fl.ir", 64'(ifa.in_ready), 64'd1);
    tick();
    check("fl.ov2", 64'(ifa.out_valid), 64'd0);
    check("fl.cnt", 64'(cnt_a), 64'd100);

    // flush coinciding with a transfer still counts
    iv = 1'b1; id = 32'h7;
    tick();
    iv = 1'b0; fl = 1'b1;
    tick();
    fl = 1'b0;
    check("flx.cnt", 64'(cnt_a), 64'd101);
    check("flx.ov", 64'(ifa.out_valid), 64'd0);

    // counter wrap on the 4-bit instance, then reset in BUSY
    do_reset();
    iv = 1'b1; ordy = 1'b1;
    for (int i = 0; i < 18; i++) begin
      id = 32'(i);
      tick();
    end
    check("wrap.cntb", 64'(cnt_b), 64'd1);
    check("wrap.cnta", 64'(cnt_a), 64'd17);
    check("wrap.occ", 64'(occ_b), 64'd1);
    rst = 1'b1;
    tick();
    chk_reset("rst1");
    rst = 1'b0; iv = 1'b0;

    // random valid/ready with scoreboard
    xn = 0; nxt = 32'h1000; stall = 1'b0; held = '0;
    for (int c = 0; c < 10000; c++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 3) != 0);
      id   = nxt;
      acc  = iv & ifa.in_ready;
      xf   = ifa.out_valid & ordy;
      if (stall && ifa.out_valid)
        check("rnd.stable", 64'(ifa.out_data), 64'(held));
      if (xf) begin
        if (sb.size() == 0) begin
          check("rnd.extra", 64'(ifa.out_data), 64'hDEAD);
        end else begin
          check("rnd.order", 64'(ifa.out_data), 64'(sb.pop_front()));
        end
        xn++;
      end
      if (acc) begin
        sb.push_back(nxt);
        nxt++;
      end
      stall = ifa.out_valid & ~ordy;
      held  = ifa.out_data;
      tick();
    end
    iv = 1'b0; ordy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (ifa.out_valid) begin
        if (sb.size() != 0)
          check("drain.order", 64'(ifa.out_data), 64'(sb.pop_front()));
        xn++;
      end
      tick();
    end
    check("rnd.left", 64'(sb.size()), 64'd0);
    check("rnd.cnt", 64'(cnt_a), 64'(xn[15:0]));
    check("rnd.cntb", 64'(cnt_b), 64'(xn[3:0]));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
